// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the traffic conflict monitor
package traffic_pkg;

  localparam int N_WAY = 4;

  typedef enum logic [1:0] {SYNC, MONITOR, FAULT} state_e;
  typedef enum logic [1:0] {RED, YEL, GRN} lamp_e;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_MULTI_GRN  = 3'd1;
  localparam logic [2:0] FC_NOT_ONEHOT = 3'd2;
  localparam logic [2:0] FC_G2R        = 3'd3;
  localparam logic [2:0] FC_YEL_LONG   = 3'd4;
  localparam logic [2:0] FC_YEL_SHORT  = 3'd5;

endpackage

// File: rtl/lamp_checker.sv
// rtl/lamp_checker.sv - per-approach lamp legality, transition and yellow-timing checks
module lamp_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW_TICKS = 1,
  parameter int MAX_YELLOW_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic r,
  input  logic y,
  input  logic g,
  input  logic tick,
  input  logic hist_en,
  output logic onehot_ok,
  output logic g2r_err,
  output logic yel_long,
  output logic yel_short,
  output logic is_green
);

  localparam int CW = $clog2(MAX_YELLOW_TICKS + 2);
  localparam logic [CW-1:0] YMAX = CW'(MAX_YELLOW_TICKS);
  localparam logic [CW-1:0] YMIN = CW'(MIN_YELLOW_TICKS);

  lamp_e         hist;
  lamp_e         cur;
  logic [CW-1:0] ycnt;
  logic          yel_held;

  // Decode the sample (green dominates yellow dominates red) and flag violations against history
  always_comb begin
    cur = RED;
    if (g) begin
      cur = GRN;
    end else if (y) begin
      cur = YEL;
    end
    onehot_ok = (r ^ y ^ g) & ~(r & y & g);
    yel_held  = (hist == YEL) && y;
    g2r_err   = (hist == GRN) && r;
    yel_long  = yel_held && tick && (ycnt == YMAX);
    yel_short = (hist == YEL) && r && (ycnt < YMIN);
    is_green  = g;
  end

  // History and yellow-hold counter; counter restarts when yellow first appears and saturates at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= RED;
      ycnt <= '0;
    end else if (hist_en) begin
      hist <= cur;
      if (y && (hist != YEL)) begin
        ycnt <= '0;
      end else if (yel_held && tick && (ycnt != YMAX)) begin
        ycnt <= ycnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - registers lamp requests and forces flashing red on conflicts
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int SETTLE_TICKS     = 4,
  parameter int MIN_YELLOW_TICKS = 1,
  parameter int MAX_YELLOW_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] r_in,
  input  logic [3:0] y_in,
  input  logic [3:0] g_in,
  input  logic       clear_fault,
  output logic [3:0] r_out,
  output logic [3:0] y_out,
  output logic [3:0] g_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);

  state_e           state, state_n;
  logic [SW-1:0]    settle, settle_n;
  logic             phase, phase_n;
  logic [3:0]       r_n, y_n, g_n;
  logic             fault_n;
  logic [2:0]       code_n;

  logic [N_WAY-1:0] onehot_ok, g2r_err, yel_long, yel_short, green;
  logic             hist_en;
  logic [2:0]       g_cnt;
  logic [2:0]       code_sel;
  logic             snapshot_legal;

  // History is frozen while a fault is latched and re-seeded on the clearing edge
  assign hist_en = (state != FAULT) || clear_fault;

  for (genvar i = 0; i < N_WAY; i++) begin : g_lamp
    lamp_checker #(
      .MIN_YELLOW_TICKS(MIN_YELLOW_TICKS),
      .MAX_YELLOW_TICKS(MAX_YELLOW_TICKS)
    ) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .r        (r_in[i]),
      .y        (y_in[i]),
      .g        (g_in[i]),
      .tick     (tick),
      .hist_en  (hist_en),
      .onehot_ok(onehot_ok[i]),
      .g2r_err  (g2r_err[i]),
      .yel_long (yel_long[i]),
      .yel_short(yel_short[i]),
      .is_green (green[i])
    );
  end

  // Green popcount and lowest-code-wins priority encoding across all approaches
  always_comb begin
    g_cnt = '0;
    for (int i = 0; i < N_WAY; i++) begin
      g_cnt = g_cnt + {2'b00, green[i]};
    end
    code_sel = FC_NONE;
    if (g_cnt > 3'd1) begin
      code_sel = FC_MULTI_GRN;
    end else if (!(&onehot_ok)) begin
      code_sel = FC_NOT_ONEHOT;
    end else if (|g2r_err) begin
      code_sel = FC_G2R;
    end else if (|yel_long) begin
      code_sel = FC_YEL_LONG;
    end else if (|yel_short) begin
      code_sel = FC_YEL_SHORT;
    end
    snapshot_legal = (&onehot_ok) && (g_cnt <= 3'd1);
  end

  // Next-state and next-output logic for SYNC / MONITOR / FAULT
  always_comb begin
    state_n  = state;
    r_n      = r_out;
    y_n      = y_out;
    g_n      = g_out;
    fault_n  = fault;
    code_n   = fault_code;
    settle_n = settle;
    phase_n  = phase;
    unique case (state)
      SYNC: begin
        r_n = '1;
        y_n = '0;
        g_n = '0;
        if (!snapshot_legal) begin
          settle_n = '0;
        end else if (tick) begin
          if (settle == SETTLE_LAST) begin
            settle_n = '0;
            state_n  = MONITOR;
          end else begin
            settle_n = settle + 1'b1;
          end
        end
      end
      MONITOR: begin
        if (code_sel != FC_NONE) begin
          state_n = FAULT;
          r_n     = '1;
          y_n     = '0;
          g_n     = '0;
          fault_n = 1'b1;
          code_n  = code_sel;
          phase_n = 1'b1;
        end else begin
          r_n = r_in;
          y_n = y_in;
          g_n = g_in;
        end
      end
      FAULT: begin
        y_n = '0;
        g_n = '0;
        if (clear_fault) begin
          state_n  = SYNC;
          r_n      = '1;
          fault_n  = 1'b0;
          code_n   = FC_NONE;
          settle_n = '0;
          phase_n  = 1'b1;
        end else if (tick) begin
          phase_n = ~phase;
          r_n     = phase ? 4'h0 : 4'hF;
        end
      end
      default: begin
        state_n = SYNC;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SYNC;
      r_out      <= 4'hF;
      y_out      <= '0;
      g_out      <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      settle     <= '0;
      phase      <= 1'b1;
    end else begin
      state      <= state_n;
      r_out      <= r_n;
      y_out      <= y_n;
      g_out      <= g_n;
      fault      <= fault_n;
      fault_code <= code_n;
      settle     <= settle_n;
      phase      <= phase_n;
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb/tb_traffic_conflict_monitor.sv - self-checking bench for traffic_conflict_monitor
module tb_traffic_conflict_monitor;

  localparam int SETTLE = 4;
  localparam int YMIN   = 1;
  localparam int YMAX   = 2;
  localparam logic [3:0] R1 = 4'b1110;
  localparam logic [3:0] G1 = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] r_in = 4'hF, y_in = 4'h0, g_in = 4'h0;
  logic       clear_fault = 1'b0;
  logic [3:0] r_out, y_out, g_out;
  logic       fault;
  logic [2:0] fault_code;

  int total = 0;
  int passed = 0;

  traffic_conflict_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .r_in       (r_in),
    .y_in       (y_in),
    .g_in       (g_in),
    .clear_fault(clear_fault),
    .r_out      (r_out),
    .y_out      (y_out),
    .g_out      (g_out),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         t;
    logic [3:0] r, y, g;
    bit         clr;
    logic [3:0] er, ey, eg;
    bit         ef;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl[19];

  // Reference model: 0=SYNC 1=MONITOR 2=FAULT; lamp 0=red 1=yellow 2=green
  int         m_state, m_settle;
  int         m_hist[4];
  int         m_ycnt[4];
  bit         m_phase, m_fault;
  int         m_code;
  logic [3:0] m_r, m_y, m_g;

  task automatic model_step(input bit rst, input bit t, input logic [3:0] r, y, g, input bit clr);
    int  greens, code;
    bit  bad_oh, g2r, lng, sht, legal;
    if (rst) begin
      m_state = 0; m_settle = 0; m_phase = 1; m_fault = 0; m_code = 0;
      m_r = 4'hF; m_y = 4'h0; m_g = 4'h0;
      for (int i = 0; i < 4; i++) begin m_hist[i] = 0; m_ycnt[i] = 0; end
      return;
    end
    greens = $countones(g);
    bad_oh = 0; g2r = 0; lng = 0; sht = 0;
    for (int i = 0; i < 4; i++) begin
      if (int'(r[i]) + int'(y[i]) + int'(g[i]) != 1) bad_oh = 1;
      if (m_hist[i] == 2 && r[i]) g2r = 1;
      if (m_hist[i] == 1 && y[i] && t && m_ycnt[i] == YMAX) lng = 1;
      if (m_hist[i] == 1 && r[i] && m_ycnt[i] < YMIN) sht = 1;
    end
    code = (greens > 1) ? 1 : bad_oh ? 2 : g2r ? 3 : lng ? 4 : sht ? 5 : 0;
    legal = !bad_oh && greens <= 1;
    if (m_state != 2 || clr) begin
      for (int i = 0; i < 4; i++) begin
        if (y[i] && m_hist[i] != 1) m_ycnt[i] = 0;
        else if (m_hist[i] == 1 && y[i] && t && m_ycnt[i] < YMAX) m_ycnt[i] = m_ycnt[i] + 1;
        m_hist[i] = g[i] ? 2 : (y[i] ? 1 : 0);
      end
    end
    case (m_state)
      0: begin
        m_r = 4'hF; m_y = 4'h0; m_g = 4'h0;
        if (!legal) m_settle = 0;
        else if (t) begin
          m_settle = m_settle + 1;
          if (m_settle == SETTLE) begin m_state = 1; m_settle = 0; end
        end
      end
      1: begin
        if (code != 0) begin
          m_state = 2; m_r = 4'hF; m_y = 4'h0; m_g = 4'h0;
          m_fault = 1; m_code = code; m_phase = 1;
        end else begin
          m_r = r; m_y = y; m_g = g;
        end
      end
      default: begin
        m_y = 4'h0; m_g = 4'h0;
        if (clr) begin
          m_state = 0; m_fault = 0; m_code = 0; m_r = 4'hF; m_settle = 0; m_phase = 1;
        end else if (t) begin
          m_phase = !m_phase;
          m_r = m_phase ? 4'hF : 4'h0;
        end
      end
    endcase
  endtask

  task automatic drive(input bit rst, input bit t, input logic [3:0] r, y, g, input bit clr);
    rst_n = !rst; tick = t; r_in = r; y_in = y; g_in = g; clear_fault = clr;
    @(posedge clk);
    model_step(rst, t, r, y, g, clr);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] er, ey, eg, input bit ef, input logic [2:0] ec);
    total++;
    if (r_out === er && y_out === ey && g_out === eg && fault === ef && fault_code === ec) begin
      passed++;
    end else begin
      $display("FAIL %s: got r=%h y=%h g=%h fault=%0d code=%0d, expected r=%h y=%h g=%h fault=%0d code=%0d",
               name, r_out, y_out, g_out, fault, fault_code, er, ey, eg, ef, ec);
    end
  endtask

  function automatic vec_t mkv(bit t, logic [3:0] r, y, g, bit clr, logic [3:0] er, ey, eg, bit ef, logic [2:0] ec);
    vec_t v;
    v.t = t; v.r = r; v.y = y; v.g = g; v.clr = clr;
    v.er = er; v.ey = ey; v.eg = eg; v.ef = ef; v.ec = ec;
    return v;
  endfunction

  // Clear a latched fault with the given legal inputs, settle for four ticks, confirm MONITOR passes inputs
  task automatic resettle(input string name, input logic [3:0] r, y, g);
    drive(0, 0, r, y, g, 1);
    check({name, "_clear"}, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    for (int i = 0; i < SETTLE; i++) drive(0, 1, r, y, g, 0);
    drive(0, 0, r, y, g, 0);
    check({name, "_monitor"}, r, y, g, 0, 3'd0);
  endtask

  int lamp[4];

  initial begin
    // Directed scenario: settle, multi-green fault, flashing, clear, settle restart
    tbl[0]  = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[1]  = mkv(0, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[2]  = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[3]  = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[4]  = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[5]  = mkv(0, R1, 4'h0, G1, 0, R1, 4'h0, G1, 0, 3'd0);
    tbl[6]  = mkv(1, 4'b1100, 4'h0, 4'b0011, 0, 4'hF, 4'h0, 4'h0, 1, 3'd1);
    tbl[7]  = mkv(0, 4'b1100, 4'h0, 4'b0011, 0, 4'hF, 4'h0, 4'h0, 1, 3'd1);
    tbl[8]  = mkv(1, 4'b1100, 4'h0, 4'b0011, 0, 4'h0, 4'h0, 4'h0, 1, 3'd1);
    tbl[9]  = mkv(1, 4'b1100, 4'h0, 4'b0011, 0, 4'hF, 4'h0, 4'h0, 1, 3'd1);
    tbl[10] = mkv(0, 4'h0, 4'h0, 4'hF, 0, 4'hF, 4'h0, 4'h0, 1, 3'd1);
    tbl[11] = mkv(1, R1, 4'h0, G1, 1, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[12] = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[13] = mkv(1, 4'b1100, 4'h0, 4'b0011, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[14] = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[15] = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[16] = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[17] = mkv(1, R1, 4'h0, G1, 0, 4'hF, 4'h0, 4'h0, 0, 3'd0);
    tbl[18] = mkv(0, R1, 4'h0, G1, 0, R1, 4'h0, G1, 0, 3'd0);

    drive(1, 0, 4'hF, 4'h0, 4'h0, 0);
    check("reset", 4'hF, 4'h0, 4'h0, 0, 3'd0);

    for (int i = 0; i < 19; i++) begin
      drive(0, tbl[i].t, tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].clr);
      check($sformatf("tbl%0d", i), tbl[i].er, tbl[i].ey, tbl[i].eg, tbl[i].ef, tbl[i].ec);
    end

    // A: yellow held one tick then red is fine; approach 2 green->red directly is code 3
    drive(0, 0, 4'b1110, 4'b0001, 4'b0000, 0);
    check("a_g2y", 4'b1110, 4'b0001, 4'b0000, 0, 3'd0);
    drive(0, 1, 4'b1110, 4'b0001, 4'b0000, 0);
    check("a_yhold", 4'b1110, 4'b0001, 4'b0000, 0, 3'd0);
    drive(0, 1, 4'b1101, 4'b0000, 4'b0010, 0);
    check("a_y2r_ok", 4'b1101, 4'b0000, 4'b0010, 0, 3'd0);
    drive(0, 1, 4'b1111, 4'b0000, 4'b0000, 0);
    check("a_g2r", 4'hF, 4'h0, 4'h0, 1, 3'd3);

    // B: approach 3 yellow held across three ticks faults on the third
    resettle("b", 4'b1011, 4'h0, 4'b0100);
    drive(0, 0, 4'b1011, 4'b0100, 4'h0, 0);
    check("b_yel", 4'b1011, 4'b0100, 4'h0, 0, 3'd0);
    drive(0, 1, 4'b1011, 4'b0100, 4'h0, 0);
    check("b_tick1", 4'b1011, 4'b0100, 4'h0, 0, 3'd0);
    drive(0, 1, 4'b1011, 4'b0100, 4'h0, 0);
    check("b_tick2", 4'b1011, 4'b0100, 4'h0, 0, 3'd0);
    drive(0, 0, 4'b1011, 4'b0100, 4'h0, 0);
    check("b_notick", 4'b1011, 4'b0100, 4'h0, 0, 3'd0);
    drive(0, 1, 4'b1011, 4'b0100, 4'h0, 0);
    check("b_tick3", 4'hF, 4'h0, 4'h0, 1, 3'd4);

    // C: dark approach 4 and double green together -> multi-green wins
    resettle("c", R1, 4'h0, G1);
    drive(0, 1, 4'b0100, 4'h0, 4'b0011, 0);
    check("c_prio", 4'hF, 4'h0, 4'h0, 1, 3'd1);

    // E: approach 2 showing red and yellow together -> code 2
    resettle("e", R1, 4'h0, G1);
    drive(0, 0, 4'b1110, 4'b0010, 4'b0001, 0);
    check("e_onehot", 4'hF, 4'h0, 4'h0, 1, 3'd2);

    // D: yellow dropped to red without any tick -> code 5, then reset mid-fault
    resettle("d", R1, 4'h0, G1);
    drive(0, 0, 4'b1110, 4'b0001, 4'h0, 0);
    check("d_yel", 4'b1110, 4'b0001, 4'h0, 0, 3'd0);
    drive(0, 0, 4'b1111, 4'h0, 4'h0, 0);
    check("d_short", 4'hF, 4'h0, 4'h0, 1, 3'd5);
    drive(0, 1, 4'b1111, 4'h0, 4'h0, 0);
    check("d_flash", 4'h0, 4'h0, 4'h0, 1, 3'd5);
    drive(1, 0, R1, 4'h0, G1, 0);
    check("d_reset", 4'hF, 4'h0, 4'h0, 0, 3'd0);
    drive(0, 0, R1, 4'h0, G1, 1);
    check("d_sync", 4'hF, 4'h0, 4'h0, 0, 3'd0);

    // Randomized: a loose sequencer with occasional corruption, checked against the model
    drive(1, 0, 4'hF, 4'h0, 4'h0, 0);
    for (int i = 0; i < 4; i++) lamp[i] = 0;
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] rr, yy, gg;
      int k;
      bit other_green;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 3);
        other_green = 0;
        for (int j = 0; j < 4; j++) if (j != k && lamp[j] == 2) other_green = 1;
        case (lamp[k])
          0: if (!other_green) lamp[k] = ($urandom_range(0, 7) == 0) ? 1 : 2;
          2: lamp[k] = ($urandom_range(0, 15) == 0) ? 0 : 1;
          default: lamp[k] = ($urandom_range(0, 7) == 0) ? 2 : 0;
        endcase
      end
      for (int j = 0; j < 4; j++) begin
        rr[j] = (lamp[j] == 0); yy[j] = (lamp[j] == 1); gg[j] = (lamp[j] == 2);
      end
      if ($urandom_range(0, 15) == 0) begin
        rr = 4'($urandom); yy = 4'($urandom); gg = 4'($urandom);
      end
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), rr, yy, gg,
            ($urandom_range(0, 19) == 0));
      check($sformatf("rand%0d", n), m_r, m_y, m_g, m_fault, 3'(m_code));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
